// File: rtl/bch_job_ctrl.sv
// Job sequencer between the register block and the BCH(31,16) codec engine.
// Optional watchdog/abort path is enabled by defining BCH_CTRL_TIMEOUT_EN.
module bch_job_ctrl #(
    parameter int unsigned MSG_W   = 16,
    parameter int unsigned CW_W    = 31,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    input  logic            cmd_mode,
    input  logic [CW_W-1:0] cmd_data,
    output logic            cmd_ready,
    input  logic            irq_clr,
    output logic            eng_start,
    output logic            eng_abort,
    output logic            eng_mode,
    output logic [CW_W-1:0] eng_din,
    input  logic            eng_done,
    input  logic [CW_W-1:0] eng_dout,
    input  logic [1:0]      eng_nerr,
    input  logic            eng_fail,
    output logic            busy,
    output logic [CW_W-1:0] res_data,
    output logic [1:0]      res_status,
    output logic [1:0]      res_nerr,
    output logic            done_irq,
    output logic            cmd_drop,
    output logic [15:0]     job_cnt,
    output logic [7:0]      led
);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StAbort} state_e;

    localparam logic [1:0] StatOk      = 2'b00;
    localparam logic [1:0] StatCorr    = 2'b01;
    localparam logic [1:0] StatFail    = 2'b10;
    localparam logic [1:0] StatTimeout = 2'b11;

    // Encode operands only carry MSG_W message bits; the rest must reach the engine as 0.
    localparam logic [CW_W-1:0] MsgMask = CW_W'((64'd1 << MSG_W) - 64'd1);

    state_e state_q;
    logic   done_set;
    logic   drop_set;

`ifdef BCH_CTRL_TIMEOUT_EN
    localparam int unsigned     TimerW    = $clog2(TIMEOUT + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
    logic [TimerW-1:0] timer_q;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        done_set  = (state_q == StWait && eng_done);
`ifdef BCH_CTRL_TIMEOUT_EN
        done_set  = done_set || (state_q == StAbort);
`endif
        drop_set  = cmd_valid && (state_q != StIdle);
        led       = {busy, done_irq, cmd_drop, res_status, job_cnt[2:0]};
    end

`ifndef BCH_CTRL_TIMEOUT_EN
    assign eng_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            eng_start  <= 1'b0;
            eng_mode   <= 1'b0;
            eng_din    <= '0;
            res_data   <= '0;
            res_status <= StatOk;
            res_nerr   <= 2'b00;
            done_irq   <= 1'b0;
            cmd_drop   <= 1'b0;
            job_cnt    <= 16'h0000;
`ifdef BCH_CTRL_TIMEOUT_EN
            eng_abort  <= 1'b0;
            timer_q    <= '0;
`endif
        end else begin
            eng_start <= 1'b0;
`ifdef BCH_CTRL_TIMEOUT_EN
            eng_abort <= 1'b0;
`endif
            // Set events take priority over a simultaneous clear.
            if (done_set) begin
                done_irq <= 1'b1;
            end else if (irq_clr) begin
                done_irq <= 1'b0;
            end
            if (drop_set) begin
                cmd_drop <= 1'b1;
            end else if (irq_clr) begin
                cmd_drop <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        state_q   <= StLaunch;
                        eng_start <= 1'b1;
                        eng_mode  <= cmd_mode;
                        eng_din   <= cmd_mode ? cmd_data : (cmd_data & MsgMask);
                    end
                end
                StLaunch: begin
`ifdef BCH_CTRL_TIMEOUT_EN
                    timer_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    if (eng_done) begin
                        res_data <= eng_dout;
                        if (eng_mode) begin
                            res_nerr <= eng_nerr;
                            if (eng_fail) begin
                                res_status <= StatFail;
                            end else if (eng_nerr != 2'b00) begin
                                res_status <= StatCorr;
                            end else begin
                                res_status <= StatOk;
                            end
                        end else begin
                            res_nerr   <= 2'b00;
                            res_status <= StatOk;
                        end
                        job_cnt <= sat_inc(job_cnt);
                        state_q <= StIdle;
                    end
`ifdef BCH_CTRL_TIMEOUT_EN
                    else if (timer_q == TimerLast) begin
                        eng_abort <= 1'b1;
                        state_q   <= StAbort;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
`endif
                end
                StAbort: begin
`ifdef BCH_CTRL_TIMEOUT_EN
                    res_data   <= '0;
                    res_nerr   <= 2'b00;
                    res_status <= StatTimeout;
                    job_cnt    <= sat_inc(job_cnt);
`endif
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/bch_job_ctrl.md
# bch_job_ctrl

Job sequencer between the AXI-Lite register block and the BCH(31,16) codec engine. Accepts one encode or decode command at a time from register-decoded strobes, launches the engine with a start pulse, and waits for completion under a watchdog. It captures the codeword or message and the error status into result registers, then raises a sticky completion flag and counts jobs. It also drives the board LEDs with live status.

## Interface
- MSG_W, 16, message width (encode operand = cmd_data[MSG_W-1:0])
- CW_W, 31, codeword width
- TIMEOUT, 1023, maximum WAIT cycles before abort (≥1)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  one-cycle command strobe (CTRL.start write)
- cmd_mode  in  1  0 = encode, 1 = decode
- cmd_data  in  CW_W  operand
- cmd_ready  out  1  high in IDLE only
- irq_clr  in  1  one-cycle clear of done_irq and cmd_drop
- eng_start  out  1  one-cycle engine launch pulse
- eng_abort  out  1  one-cycle engine abort pulse
- eng_mode  out  1  latched cmd_mode
- eng_din  out  CW_W  latched cmd_data (encode: upper bits zeroed)
- eng_done  in  1  one-cycle completion pulse
- eng_dout  in  CW_W  engine result, valid with eng_done
- eng_nerr  in  2  corrected bit count, valid with eng_done
- eng_fail  in  1  uncorrectable flag, valid with eng_done
- busy  out  1  state ≠ IDLE
- res_data  out  CW_W  last result
- res_status  out  2  00 ok, 01 corrected, 10 uncorrectable, 11 timeout
- res_nerr  out  2  last corrected count
- done_irq  out  1  sticky completion flag
- cmd_drop  out  1  sticky: command arrived while busy
- job_cnt  out  16  completed jobs, saturating at 0xFFFF
- led  out  8  {busy, done_irq, cmd_drop, res_status, job_cnt[2:0]}

## Operation
- FSM: IDLE → LAUNCH → WAIT → IDLE (normal), WAIT → ABORT → IDLE (timeout).
- IDLE: cmd_ready=1. On cmd_valid, latch mode and data, then go to LAUNCH.
- LAUNCH: eng_start=1 for exactly one cycle; clear the timer; go to WAIT.
- WAIT, when eng_done is sampled:
  - res_data←eng_dout.
  - Encode: res_nerr←0, res_status←00.
  - Decode: res_nerr←eng_nerr; res_status←10 if eng_fail, else 01 if eng_nerr≠0, else 00.
  - Set done_irq; job_cnt+1 unless already 0xFFFF; go to IDLE.
- WAIT, no eng_done: timer+1. When TIMEOUT WAIT cycles have elapsed without eng_done, go to ABORT.
- ABORT: eng_abort=1 for one cycle; res_data←0, res_nerr←0, res_status←11; set done_irq; job_cnt+1 (saturating); go to IDLE.
- cmd_valid outside IDLE: command ignored, cmd_drop set.
- eng_done outside WAIT: ignored.
- irq_clr clears done_irq and cmd_drop. If a set event occurs in the same cycle, set wins.
- Timer width: $clog2(TIMEOUT+1).

## Timing
- Reset (rst=0, asynchronous): state IDLE; all registered outputs 0, including res_*, job_cnt, done_irq, cmd_drop, eng_*. cmd_ready=1 because it is decoded from IDLE.
- cmd_valid sampled at edge 0:
  - busy=1, cmd_ready=0, eng_start=1 in cycle 1.
  - Eng_din/eng_mode stable from cycle 1 until return to IDLE.
- eng_done sampled in WAIT at cycle k (k≥2): res_*, done_irq and job_cnt updated, busy=0 and cmd_ready=1 from cycle k+1. The next command is accepted at cycle k+1, with no bubble.
- Fastest job: eng_done in cycle 2 → results visible in cycle 3.
- Timeout: with no eng_done in cycles 2..TIMEOUT+1, ABORT occurs in cycle TIMEOUT+2. Status 11 is visible and the FSM is in IDLE from cycle TIMEOUT+3.
- eng_done in the last WAIT cycle: completion wins, no abort.
- Reset mid-job: immediate return to IDLE, no eng_abort pulse, results cleared.

## Configuration
- BCH_CTRL_TIMEOUT_EN defined: watchdog, ABORT state and status 11 present as above.
- BCH_CTRL_TIMEOUT_EN undefined: no timer; WAIT holds until eng_done indefinitely; eng_abort tied 0; status 11 never produced; TIMEOUT unused.

## Test plan
- Reset, then check outputs: all outputs 0 except cmd_ready=1; led=0x00.
- Encode: cmd_data=0x0000_ABCD, mode 0; engine returns eng_dout=0x55E6_ABCD with eng_done at cycle 4.
  - eng_din=0x0000_ABCD.
  - res_data=0x55E6_ABCD, res_status=00, job_cnt=1 from cycle 5.
- Decode, corrected then failed:
  - eng_nerr=2, eng_fail=0 → res_status=01, res_nerr=2.
  - Next job: eng_fail=1 → res_status=10.
  - job_cnt=2.
- Timeout (macro defined, TIMEOUT=8): engine never responds.
  - eng_abort pulses in cycle 10.
  - res_status=11, res_data=0, done_irq=1.
  - A late eng_done is ignored.
- Contention: cmd_valid in cycle 2 while busy, and irq_clr in the same cycle as completion.
  - The cycle-2 command is ignored and cmd_drop=1.
  - done_irq stays 1; a later irq_clr clears both flags.
- Saturation and reset: preload job_cnt=0xFFFE and run 3 jobs → job_cnt=0xFFFF. Assert rst during WAIT → immediate IDLE, job_cnt=0.
